// File: rtl/kulisch_pkg.sv
// Shared definitions for the Kulisch carry-save accumulator datapath.
package kulisch_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } kulisch_state_t;

  localparam int DEF_DWIDTH    = 11;
  localparam int DEF_ACC_WIDTH = 80;
  localparam int DEF_SHIFT_W   = 7;
  localparam int MAX_SHIFT     = DEF_ACC_WIDTH - 2 * DEF_DWIDTH;

endpackage : kulisch_pkg

// File: rtl/kulisch_align_stage.sv
// Stage 1: resolves the carry-save product, sign-extends it to the
// accumulator width, applies the alignment shift and flags illegal shifts.
module kulisch_align_stage #(
  parameter int DWIDTH    = 11,
  parameter int ACC_WIDTH = 80,
  parameter int SHIFT_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic [2*DWIDTH-1:0]    sum,
  input  logic [2*DWIDTH-1:0]    carry,
  input  logic [SHIFT_W-1:0]     shift,
  output logic                   aligned_valid,
  output logic [ACC_WIDTH-1:0]   aligned,
  output logic                   illegal
);

  localparam int PW    = 2 * DWIDTH;
  localparam int EXT_W = ACC_WIDTH - PW;
  localparam logic [SHIFT_W:0] MAX_SHIFT_V = (SHIFT_W + 1)'(ACC_WIDTH - PW);

  logic [PW-1:0]        product;
  logic [ACC_WIDTH-1:0] extended;
  logic [ACC_WIDTH-1:0] shifted;
  logic                 legal;

  // Carry-save resolve (wraps modulo 2^PW), sign-extend, align.
  always_comb begin
    product  = sum + carry;
    extended = {{EXT_W{product[PW-1]}}, product};
    shifted  = extended << shift;
    legal    = ({1'b0, shift} <= MAX_SHIFT_V);
  end

  // Stage-1 pipeline register; an illegal shift contributes zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aligned_valid <= 1'b0;
      aligned       <= '0;
      illegal       <= 1'b0;
    end else begin
      aligned_valid <= valid;
      if (valid) begin
        aligned <= legal ? shifted : '0;
        illegal <= !legal;
      end
    end
  end

endmodule : kulisch_align_stage

// File: rtl/kulisch_cs_accumulator.sv
// Exact Kulisch accumulator for carry-save product beats with a
// valid/ready result port and auto-clear after each result is taken.
module kulisch_cs_accumulator
  import kulisch_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SHIFT_W   = DEF_SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*DWIDTH-1:0]  in_sum,
  input  logic [2*DWIDTH-1:0]  in_carry,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_overflow
);

  kulisch_state_t       state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic                 s1_valid;
  logic [ACC_WIDTH-1:0] s1_val;
  logic                 s1_ovf;
  logic                 accept;
  logic                 take;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 add_ovf;

  kulisch_align_stage #(
    .DWIDTH   (DWIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .SHIFT_W  (SHIFT_W)
  ) u_align (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (accept),
    .sum          (in_sum),
    .carry        (in_carry),
    .shift        (in_shift),
    .aligned_valid(s1_valid),
    .aligned      (s1_val),
    .illegal      (s1_ovf)
  );

  // Handshakes and the stage-2 adder with signed-overflow detection.
  always_comb begin
    accept   = in_valid & in_ready;
    take     = out_valid & out_ready;
    acc_next = acc + s1_val;
    add_ovf  = (acc[ACC_WIDTH-1] == s1_val[ACC_WIDTH-1]) &&
               (acc_next[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  end

  // Stage 2: accumulate aligned products; cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (take) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (s1_valid) begin
      acc    <= acc_next;
      sticky <= sticky | s1_ovf | add_ovf;
    end
  end

  // Control FSM with registered handshake and result outputs.
  // The first OUT cycle snapshots acc (already final after FLUSH), so
  // out_valid rises two edges after the last beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state <= OUT;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid    <= 1'b1;
            out_acc      <= acc;
            out_overflow <= sticky;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : kulisch_cs_accumulator

// File: tb/tb_kulisch_cs_accumulator.sv
// Directed, table-driven bench for kulisch_cs_accumulator.
module tb_kulisch_cs_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_sum;
  logic [21:0] in_carry;
  logic [6:0]  in_shift;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_acc;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;
  int first_cyc;

  typedef struct {
    logic [21:0] sum;
    logic [21:0] carry;
    logic [6:0]  shift;
    logic        last;
    logic [79:0] exp_acc;
    logic        exp_ovf;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  kulisch_cs_accumulator #(
    .DWIDTH   (11),
    .ACC_WIDTH(80),
    .SHIFT_W  (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_shift    (in_shift),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [21:0] s, input logic [21:0] c, input logic [6:0] sh,
                         input logic l, input logic [79:0] ea, input logic eo, input int h);
    vec_t v;
    v.sum = s; v.carry = c; v.shift = sh; v.last = l;
    v.exp_acc = ea; v.exp_ovf = eo; v.hold = h;
    vecs.push_back(v);
  endtask

  // Presents one beat from a negedge and returns #1 after the accepting edge.
  task automatic send_beat(input logic [21:0] s, input logic [21:0] c, input logic [6:0] sh,
                           input logic l);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_shift = sh;
    in_last  = l;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  // Latency, result, hold-stability and auto-clear handshake after a last beat.
  task automatic check_result(input logic [79:0] ea, input logic eo, input int hold);
    in_valid = 1'b0;
    check("in_ready_flush", {79'd0, in_ready}, 80'd0);
    @(posedge clk); #1;
    check("out_valid_early", {79'd0, out_valid}, 80'd0);
    @(posedge clk); #1;
    check("out_valid_lat2", {79'd0, out_valid}, 80'd1);
    check("out_acc", out_acc, ea);
    check("out_overflow", {79'd0, out_overflow}, {79'd0, eo});
    check("in_ready_out", {79'd0, in_ready}, 80'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {79'd0, out_valid}, 80'd1);
      check("hold_acc", out_acc, ea);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_taken", {79'd0, out_valid}, 80'd0);
    check("in_ready_back", {79'd0, in_ready}, 80'd1);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_shift  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // product = sum + carry mod 2^22, sign-extended, << shift
    add_vec(22'h00000A, 22'h000005, 7'd0,  1'b1, 80'd15, 1'b0, 0);
    add_vec(22'h000007, 22'h000000, 7'd0,  1'b1, 80'd7,  1'b0, 0);
    add_vec(22'h3FFFF1, 22'h000000, 7'd4,  1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FF10, 1'b0, 0);
    add_vec(22'h000000, 22'h000001, 7'd0,  1'b0, 80'd0,  1'b0, 0);
    add_vec(22'h000001, 22'h000001, 7'd1,  1'b0, 80'd0,  1'b0, 0);
    add_vec(22'h000002, 22'h000001, 7'd2,  1'b0, 80'd0,  1'b0, 0);
    add_vec(22'h000003, 22'h000001, 7'd3,  1'b1, 80'd49, 1'b0, 5);
    add_vec(22'h1FFFFF, 22'h000000, 7'd58, 1'b0, 80'd0,  1'b0, 0);
    // 2*(2^21-1)*2^58 = 2^80 - 2^59 wraps to -2^59
    add_vec(22'h1FFFFF, 22'h000000, 7'd58, 1'b1, 80'hFFFF_F800_0000_0000_0000, 1'b1, 0);
    add_vec(22'h000005, 22'h000000, 7'd59, 1'b1, 80'd0,  1'b1, 0);
    add_vec(22'h3FFFFF, 22'h000003, 7'd1,  1'b1, 80'd4,  1'b0, 0);
    add_vec(22'h3FFFFF, 22'h000000, 7'd58, 1'b1, 80'hFFFF_FC00_0000_0000_0000, 1'b0, 0);

    #12;
    check("rst_in_ready", {79'd0, in_ready}, 80'd1);
    check("rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("rst_out_acc", out_acc, 80'd0);
    check("rst_out_overflow", {79'd0, out_overflow}, 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    first_cyc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      send_beat(vecs[i].sum, vecs[i].carry, vecs[i].shift, vecs[i].last);
      if (i == 3) first_cyc = acc_cyc;
      if (i == 6) check("stream_4_in_4", 80'(acc_cyc - first_cyc), 80'd3);
      if (vecs[i].last) check_result(vecs[i].exp_acc, vecs[i].exp_ovf, vecs[i].hold);
    end

    // Asynchronous reset in the middle of FLUSH discards the in-flight beat.
    send_beat(22'h000003, 22'h000000, 7'd0, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_in_ready", {79'd0, in_ready}, 80'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {79'd0, out_valid}, 80'd0);
    check("async_rst_in_ready", {79'd0, in_ready}, 80'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(22'h000005, 22'h000000, 7'd0, 1'b1);
    check_result(80'd5, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_kulisch_cs_accumulator
